frq_mode_ctrl: RTL
==================

Name: frq_mode_ctrl

Overview:
Run/pause/clear and rate-mode controller for the BCD counter datapath. Cascades divide-by-STAGE_DIV prescaler stages from mclk and emits a one-cycle count-enable tick at the selected decade rate. Button inputs select the rate and sequence the counter. Sits between the board buttons and the BCD counter / segment display chain.

Parameters:
STAGE_DIV, 10, mclk cycles per stage-0 tick and fan-in ratio of each later stage (>=2)
NUM_MODES, 4, number of cascaded stages and selectable rates (1..4)

Ports:
mclk  in  1  master clock
rst  in  1  asynchronous, active-high reset
btn_run  in  1  raw run/pause button, level, asynchronous to mclk
btn_mode  in  1  raw mode-advance button, level, asynchronous
btn_clr  in  1  raw clear button, level, asynchronous
tick  out  1  one-cycle count enable to BCD counter, registered
clr  out  1  one-cycle synchronous clear to BCD counter, registered
mode  out  2  selected rate index; tick period = STAGE_DIV^(mode+1) cycles
running  out  1  high while state==RUN
state  out  2  FSM state, for debug/LEDs

Behaviour:
- Reset (rst=1, async): tick=0, clr=0, mode=0, running=0, state=IDLE, all prescaler counters 0, synchronizers 0.
- Each button: 2-FF synchronizer, then rising-edge detect -> one-cycle press pulse. Button rise to press pulse = 3 mclk. A held button gives one press only. Debounce is upstream.
- Prescaler stage k: counter of width clog2(STAGE_DIV), counts 0..STAGE_DIV-1 and wraps.
- Stage 0 increments every cycle while state==RUN. Stage k>0 increments on s_tick[k-1].
- s_tick[k] = stage enable AND counter==STAGE_DIV-1 (combinational), so stages stay aligned.
- tick <= s_tick[mode]. The first tick is high exactly STAGE_DIV^(mode+1) cycles after the first RUN cycle, then repeats with that period.
- FSM encoding: IDLE=0, RUN=1, PAUSE=2, CLEAR=3.
  - IDLE: run press -> RUN; clr press -> CLEAR.
  - RUN: run press -> PAUSE; clr press -> CLEAR.
  - PAUSE: counters hold their values. Run press -> RUN, resuming from the held count. Clr press -> CLEAR.
  - CLEAR: lasts one cycle. clr=1, all prescaler counters zeroed, then -> IDLE unconditionally.
- Simultaneous run and clr presses: clr wins.
- Mode press, in any state: mode <= (mode+1) mod NUM_MODES, all prescaler counters zeroed, tick forced 0 that cycle, state unchanged.
- Mode press together with clr: both take effect.
- tick and clr are never high in the same cycle. tick is 0 in every state except RUN.
- rst asserted mid-operation: immediate return to reset values; no partial tick.

Optional Feature:
FRQ_STEP_EN
- Defined: adds input btn_step (raw, conditioned like the other buttons). A step press in PAUSE produces exactly one tick, registered one cycle after the press pulse. Prescaler counters are unchanged. A step press in any other state is ignored.
- Undefined: the btn_step port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package frq_pkg: state encodings IDLE/RUN/PAUSE/CLEAR, MODE_W=2, default STAGE_DIV.
- Sub-module frq_div_stage (ports: mclk, rst, clr, en, stage_tick), instantiated NUM_MODES times in a generate loop.
- Button conditioning stays inline.

Test Plan:
- Reset, then btn_run pulse, mode 0 -> state=RUN; first tick 10 cycles after RUN entry, then every 10 cycles; clr stays 0.
- Two btn_mode presses while running -> mode=2, counters cleared, next tick 1000 cycles after the second press, then period 1000.
- Mode 0: pause when the stage-0 count is 4, wait 50 cycles, press run -> no tick while paused; next tick 6 cycles after RUN re-entry.
- btn_run and btn_clr pressed in the same cycle during RUN -> state CLEAR for exactly one cycle with clr=1, then IDLE; no tick.
- Four mode presses from mode 0 -> sequence 1, 2, 3, 0; with NUM_MODES=3, three presses -> 1, 2, 0.
- rst asserted mid-RUN between ticks -> all outputs 0 asynchronously; after release, state=IDLE and no tick until a run press.

Source files
------------

// File: rtl/frq_pkg.sv
// Shared types and constants for the frequency-counter mode controller.
// FRQ_STEP_EN (optional) adds a fourth button, the single-step input.
package frq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    CLEAR = 2'd3
  } state_e;

  localparam int MODE_W        = 2;
  localparam int DEF_STAGE_DIV = 10;
  localparam int MAX_MODES     = 4;

  // Bit positions of each button inside the conditioning vectors.
  localparam int BTN_RUN  = 0;
  localparam int BTN_MODE = 1;
  localparam int BTN_CLR  = 2;
`ifdef FRQ_STEP_EN
  localparam int BTN_STEP = 3;
  localparam int NUM_BTN  = 4;
`else
  localparam int NUM_BTN  = 3;
`endif

  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] cur,
                                                  input int              num_modes);
    if (int'(cur) >= num_modes - 1) return '0;
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/frq_div_stage.sv
// One decade prescaler stage: counts 0..STAGE_DIV-1 while enabled and
// flags the wrap cycle combinationally so cascaded stages stay aligned.
module frq_div_stage
  import frq_pkg::*;
#(
  parameter int STAGE_DIV = DEF_STAGE_DIV
) (
  input  logic mclk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic stage_tick
);

  localparam int              CNT_W = (STAGE_DIV > 1) ? $clog2(STAGE_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STAGE_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign stage_tick = en & (r_cnt == LAST);

  // NOTE: asynchronous reset must appear in the sensitivity list; state uses <= only.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (stage_tick) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/frq_mode_ctrl.sv
// Run/pause/clear FSM plus cascaded decade prescaler producing the count tick.
// Define FRQ_STEP_EN to add btn_step (one tick per press while paused).
module frq_mode_ctrl
  import frq_pkg::*;
#(
  parameter int STAGE_DIV = DEF_STAGE_DIV,
  parameter int NUM_MODES = MAX_MODES
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              btn_run,
  input  logic              btn_mode,
  input  logic              btn_clr,
`ifdef FRQ_STEP_EN
  input  logic              btn_step,
`endif
  output logic              tick,
  output logic              clr,
  output logic [MODE_W-1:0] mode,
  output logic              running,
  output logic [1:0]        state
);

  logic [NUM_BTN-1:0]   w_btn;
  logic [NUM_BTN-1:0]   r_sync1;
  logic [NUM_BTN-1:0]   r_sync2;
  logic [NUM_BTN-1:0]   r_sync3;
  logic [NUM_BTN-1:0]   r_press;
  logic                 w_run_p;
  logic                 w_mode_p;
  logic                 w_clr_p;
`ifdef FRQ_STEP_EN
  logic                 w_step_p;
`endif

  logic [NUM_MODES-1:0] w_stage_en;
  logic [NUM_MODES-1:0] w_stage_tick;
  logic [MAX_MODES-1:0] w_tick_pad;
  logic                 w_sel_tick;
  logic                 w_cnt_clr;

  state_e               r_state;
  logic [MODE_W-1:0]    r_mode;
  logic                 r_tick;
  logic                 r_clr;
  logic                 r_running;

`ifdef FRQ_STEP_EN
  assign w_btn = {btn_step, btn_clr, btn_mode, btn_run};
`else
  assign w_btn = {btn_clr, btn_mode, btn_run};
`endif

  // Two-flop synchronizer, a third flop for edge history, then a registered
  // rising-edge pulse: a button rise shows up as a press three clocks later.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
      r_press <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_press <= r_sync2 & ~r_sync3;
    end
  end

  assign w_run_p  = r_press[BTN_RUN];
  assign w_mode_p = r_press[BTN_MODE];
  assign w_clr_p  = r_press[BTN_CLR];
`ifdef FRQ_STEP_EN
  assign w_step_p = r_press[BTN_STEP];
`endif

  // A mode change restarts the rate from zero, as does the CLEAR state.
  assign w_cnt_clr = w_mode_p | (r_state == CLEAR);

  genvar k;
  for (k = 0; k < NUM_MODES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_stage_en[k] = (r_state == RUN);
    end else begin : g_next
      assign w_stage_en[k] = w_stage_tick[k-1];
    end

    frq_div_stage #(
      .STAGE_DIV (STAGE_DIV)
    ) u_stage (
      .mclk       (mclk),
      .rst        (rst),
      .clr        (w_cnt_clr),
      .en         (w_stage_en[k]),
      .stage_tick (w_stage_tick[k])
    );
  end

  // NOTE: every variable written in always_comb gets a default first, so no latch.
  always_comb begin
    w_tick_pad                = '0;
    w_tick_pad[NUM_MODES-1:0] = w_stage_tick;
  end

  assign w_sel_tick = w_tick_pad[r_mode];

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mode    <= '0;
      r_tick    <= 1'b0;
      r_clr     <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_clr  <= 1'b0;

      if (w_mode_p) begin
        r_mode <= next_mode(r_mode, NUM_MODES);
      end

      // Clear has priority over run in every state that accepts presses.
      case (r_state)
        IDLE: begin
          if (w_clr_p) begin
            r_state <= CLEAR;
            r_clr   <= 1'b1;
          end else if (w_run_p) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          if (w_clr_p) begin
            r_state   <= CLEAR;
            r_clr     <= 1'b1;
            r_running <= 1'b0;
          end else if (w_run_p) begin
            r_state   <= PAUSE;
            r_running <= 1'b0;
          end else begin
            r_tick <= w_sel_tick & ~w_mode_p;
          end
        end
        PAUSE: begin
          if (w_clr_p) begin
            r_state <= CLEAR;
            r_clr   <= 1'b1;
          end else if (w_run_p) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
`ifdef FRQ_STEP_EN
          else if (w_step_p) begin
            r_tick <= ~w_mode_p;
          end
`endif
        end
        CLEAR: begin
          r_state <= IDLE;
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign tick    = r_tick;
  assign clr     = r_clr;
  assign mode    = r_mode;
  assign running = r_running;
  assign state   = r_state;

endmodule
